vape_output_protection: RTL and testbench

Hardware monitor guarding the output region (OR) that an attested executable region (ER) writes its results into. It observes CPU and DMA data writes alongside the PC. It raises `exec` only after one complete ER run whose OR contents and ER code have not been touched by anything other than the ER itself since that run began. It sits beside the PC atomicity monitor in the VAPE hardware block; the attestation logic ANDs the two `exec` flags.

---
 rtl/vape_pkg.sv | 36 +++
 rtl/vape_range_check.sv | 22 ++
 rtl/vape_output_protection.sv | 148 ++++++++++++++
 tb/tb_vape_output_protection.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vape_pkg.sv
// ============================================================================
//  Module   : vape_pkg
//  Purpose  : Shared types and constants for the VAPE hardware monitors
//             (output protection and PC atomicity monitor).
//             - addr_t   : 16-bit address type
//             - bounds_t : latched ER/OR bounds
//             - state_t  : monitor state encoding (KILL/RUN/DONE)
//             - DEF_SMEM_BASE / DEF_SMEM_SIZE : secure ROM defaults
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vape_pkg;

    typedef logic [15:0] addr_t;

    localparam addr_t DEF_SMEM_BASE = 16'hA000;
    localparam addr_t DEF_SMEM_SIZE = 16'h4000;

    typedef struct packed {
        addr_t er_min;
        addr_t er_max;
        addr_t or_min;
        addr_t or_max;
    } bounds_t;

    // Encoding is fixed; 2'b11 is unused and treated as KILL by the monitors.
    typedef enum logic [1:0] {
        ST_KILL = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vape_range_check.sv
// ============================================================================
//  Module   : vape_range_check
//  Purpose  : Combinational inclusive range compare, lo <= a <= hi.
//  Ports    : a        - address under test
//             lo, hi   - inclusive bounds
//             in_range - 1 when a lies within [lo, hi]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vape_range_check (
    input  logic [15:0] a,
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    output logic        in_range
);

    assign in_range = (a >= lo) && (a <= hi);

endmodule

`default_nettype wire

// File: rtl/vape_output_protection.sv
// ============================================================================
//  Module   : vape_output_protection
//  Purpose  : Guards the output region (OR) written by an attested
//             executable region (ER). exec rises only after one complete ER
//             run whose OR contents and ER code were untouched by anything
//             other than the ER itself since that run began.
//  Ports    : clk, reset (async, active high)
//             pc, data_addr, data_wr         - CPU observation
//             dma_addr, dma_en               - DMA observation (VAPE_DMA_EN)
//             ER_min, ER_max, OR_min, OR_max - inclusive region bounds
//             exec                           - registered "valid output" flag
//  Config   : VAPE_DMA_EN - when defined, adds the DMA ports and DMA
//             writes into ER/OR count as violations. When undefined only
//             CPU writes are policed.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vape_output_protection
    import vape_pkg::*;
#(
    parameter addr_t SMEM_BASE = DEF_SMEM_BASE,
    parameter addr_t SMEM_SIZE = DEF_SMEM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic        data_wr,
`ifdef VAPE_DMA_EN
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
`endif
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    input  logic [15:0] OR_min,
    input  logic [15:0] OR_max,
    output logic        exec
);

    // Secure ROM end in 17 bits so base+size cannot wrap.
    localparam logic [16:0] c_smem_end = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

    state_t  r_state;
    state_t  w_next_state;
    addr_t   r_prev_pc;
    bounds_t r_lat;
    bounds_t w_live;
    logic    r_exec;

    logic w_pc_in_er;
    logic w_data_in_or;
    logic w_data_in_er;
    logic w_cpu_or;
    logic w_cpu_er;
    logic w_dma_hit;
    logic w_cfg_valid;
    logic w_bounds_changed;
    logic w_pc_at_er_min;

    assign w_live = '{er_min: ER_min, er_max: ER_max, or_min: OR_min, or_max: OR_max};

    vape_range_check u_pc_er   (.a(pc),        .lo(ER_min), .hi(ER_max), .in_range(w_pc_in_er));
    vape_range_check u_data_or (.a(data_addr), .lo(OR_min), .hi(OR_max), .in_range(w_data_in_or));
    vape_range_check u_data_er (.a(data_addr), .lo(ER_min), .hi(ER_max), .in_range(w_data_in_er));

`ifdef VAPE_DMA_EN
    logic w_dma_in_or;
    logic w_dma_in_er;

    vape_range_check u_dma_or (.a(dma_addr), .lo(OR_min), .hi(OR_max), .in_range(w_dma_in_or));
    vape_range_check u_dma_er (.a(dma_addr), .lo(ER_min), .hi(ER_max), .in_range(w_dma_in_er));

    assign w_dma_hit = dma_en && (w_dma_in_or || w_dma_in_er);
`else
    assign w_dma_hit = 1'b0;
`endif

    assign w_cpu_or       = data_wr && w_data_in_or;
    assign w_cpu_er       = data_wr && w_data_in_er;
    assign w_pc_at_er_min = (pc == ER_min);

    assign w_cfg_valid = (ER_min < ER_max)
                      && (OR_min <= OR_max)
                      && ((OR_max < ER_min) || (ER_max < OR_min))
                      && ((OR_max < SMEM_BASE) || ({1'b0, OR_min} > c_smem_end));

    // Latched bounds are only meaningful once a run has started.
    assign w_bounds_changed = ((r_state == ST_RUN) || (r_state == ST_DONE))
                           && (w_live != r_lat);

    // Next state. Order of tests encodes the precedence:
    // invalid config, then violations, then progress transitions.
    always_comb begin
        w_next_state = ST_KILL;
        if (w_cfg_valid) begin
            case (r_state)
                ST_RUN: begin
                    if (w_cpu_er || w_dma_hit || w_bounds_changed)
                        w_next_state = ST_KILL;
                    else if (w_pc_in_er)
                        w_next_state = ST_RUN;
                    else if (r_prev_pc == ER_max)
                        w_next_state = ST_DONE;
                    else
                        w_next_state = ST_KILL;
                end
                ST_DONE: begin
                    // A CPU OR write in the re-entry cycle is the ER's own
                    // write, so the re-entry test comes before cpu_or.
                    if (w_cpu_er || w_dma_hit || w_bounds_changed)
                        w_next_state = ST_KILL;
                    else if (w_pc_at_er_min)
                        w_next_state = ST_RUN;
                    else if (w_cpu_or)
                        w_next_state = ST_KILL;
                    else
                        w_next_state = ST_DONE;
                end
                default: begin
                    // ST_KILL and the unused 2'b11 code
                    if (w_pc_at_er_min && !w_cpu_er && !w_dma_hit)
                        w_next_state = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_KILL;
            r_prev_pc <= 16'h0000;
            r_lat     <= '0;
            r_exec    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_prev_pc <= pc;
            r_exec    <= (w_next_state == ST_DONE);
            if ((w_next_state == ST_RUN) && (r_state != ST_RUN))
                r_lat <= w_live;
        end
    end

    assign exec = r_exec;

endmodule

`default_nettype wire

// File: tb/tb_vape_output_protection.sv
// ============================================================================
//  Module   : tb_vape_output_protection
//  Purpose  : Self-checking bench for vape_output_protection: directed
//             scenarios followed by randomized PC/write traffic compared
//             against a behavioural model of the protection rules.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vape_output_protection;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_wr;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic [15:0] er_min, er_max, or_min, or_max;
    logic        exec;

    int n_cmp;
    int n_fail;

`ifdef VAPE_DMA_EN
    localparam bit c_dma_present = 1'b1;
`else
    localparam bit c_dma_present = 1'b0;
`endif

    vape_output_protection dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .data_addr (data_addr),
        .data_wr   (data_wr),
`ifdef VAPE_DMA_EN
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
`endif
        .ER_min    (er_min),
        .ER_max    (er_max),
        .OR_min    (or_min),
        .OR_max    (or_max),
        .exec      (exec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // running    : an ER execution is in progress and still clean
    // output_ok  : the last ER run completed and the OR is untouched since
    bit          m_running;
    bit          m_output_ok;
    logic [15:0] m_prev_pc;
    logic [15:0] m_lat [4];

    function automatic bit inside_incl(input logic [15:0] a, lo, hi);
        return (a >= lo) && (a <= hi);
    endfunction

    task automatic model_reset();
        m_running   = 0;
        m_output_ok = 0;
        m_prev_pc   = 16'h0000;
        for (int i = 0; i < 4; i++) m_lat[i] = 16'h0000;
    endtask

    task automatic model_edge();
        bit cfg_ok, cpu_or, cpu_er, dma_hit, moved, start_run;
        cfg_ok  = (er_min < er_max) && (or_min <= or_max)
               && ((or_max < er_min) || (er_max < or_min))
               && ((int'(or_max) < 'hA000) || (int'(or_min) > 'hA000 + 'h4000));
        cpu_or  = data_wr && inside_incl(data_addr, or_min, or_max);
        cpu_er  = data_wr && inside_incl(data_addr, er_min, er_max);
        dma_hit = c_dma_present && dma_en &&
                  (inside_incl(dma_addr, or_min, or_max) || inside_incl(dma_addr, er_min, er_max));
        moved   = (m_running || m_output_ok) &&
                  (m_lat[0] != er_min || m_lat[1] != er_max ||
                   m_lat[2] != or_min || m_lat[3] != or_max);
        start_run = 0;
        if (!cfg_ok) begin
            m_running = 0; m_output_ok = 0;
        end else if (m_running) begin
            if (cpu_er || dma_hit || moved) m_running = 0;
            else if (!inside_incl(pc, er_min, er_max)) begin
                m_running   = 0;
                m_output_ok = (m_prev_pc == er_max);
            end
        end else if (m_output_ok) begin
            if (cpu_er || dma_hit || moved) m_output_ok = 0;
            else if (pc == er_min) begin
                m_output_ok = 0; start_run = 1;
            end else if (cpu_or) m_output_ok = 0;
        end else if (pc == er_min && !cpu_er && !dma_hit) begin
            start_run = 1;
        end
        if (start_run) begin
            m_running = 1;
            m_lat[0] = er_min; m_lat[1] = er_max; m_lat[2] = or_min; m_lat[3] = or_max;
        end
        m_prev_pc = pc;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag);
        n_cmp++;
        assert (exec === m_output_ok) else begin
            n_fail++;
            $error("FAIL %s: exec observed %0b expected %0b", tag, exec, m_output_ok);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic wr, input logic [15:0] wa,
                         input logic den, input logic [15:0] da);
        pc = p; data_wr = wr; data_addr = wa; dma_en = den; dma_addr = da;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic step(input string tag, input logic [15:0] p);
        drive(p, 1'b0, 16'h3000, 1'b0, 16'h3000);
        tick(tag);
    endtask

    task automatic set_cfg(input logic [15:0] a, b, c, d);
        er_min = a; er_max = b; or_min = c; or_max = d;
    endtask

    task automatic clean_run(input string tag);
        step(tag, 16'hE000);
        drive(16'hE002, 1'b1, 16'h0200, 1'b0, 16'h3000);
        tick(tag);
        step(tag, 16'hE0FE);
        step(tag, 16'hF000);
    endtask

    // Reset asserted between clock edges must clear exec at once.
    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int r;
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        set_cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h021F);
        drive(16'h1000, 1'b0, 16'h3000, 1'b0, 16'h3000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state");
        reset = 1'b0;

        // Clean run: exec rises the cycle after the exit cycle
        clean_run("clean_run");
        step("clean_hold", 16'hF002);

        // Post-run tamper: CPU write into OR after DONE
        drive(16'hF004, 1'b1, 16'h0210, 1'b0, 16'h3000);
        tick("tamper_kill");
        step("tamper_stay", 16'hE0FE);
        step("tamper_stay2", 16'hF000);

        // DMA into OR during the run
        step("dma_run", 16'hE000);
        drive(16'hE002, 1'b0, 16'h3000, 1'b1, 16'h021F);
        tick("dma_hit");
        step("dma_run", 16'hE0FE);
        step("dma_exit", 16'hF000);

        // Early exit from mid-ER
        step("early_run", 16'hE000);
        step("early_run", 16'hE050);
        step("early_exit", 16'hF000);

        // Bound change while DONE
        clean_run("bound_run");
        or_max = 16'h0220;
        step("bound_change", 16'hF000);
        or_max = 16'h021F;
        step("bound_restore", 16'hF002);

        // Re-entry from DONE with the ER's own OR write in that cycle
        clean_run("reentry_run");
        drive(16'hE000, 1'b1, 16'h0200, 1'b0, 16'h3000);
        tick("reentry_or_write");
        step("reentry_body", 16'hE0FE);
        step("reentry_exit", 16'hF000);

        // ER write while re-entering kills
        drive(16'hE000, 1'b1, 16'hE010, 1'b0, 16'h3000);
        tick("reentry_er_write");
        step("reentry_er_after", 16'hE0FE);
        step("reentry_er_exit", 16'hF000);

        // Invalid config: OR inside secure ROM
        set_cfg(16'hE000, 16'hE0FE, 16'hA100, 16'hA1FF);
        clean_run("invalid_cfg");
        set_cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h021F);

        // Async reset during RUN and during DONE
        step("rst_run", 16'hE000);
        step("rst_run", 16'hE002);
        async_reset_check("async_reset_run");
        clean_run("rst_done_run");
        async_reset_check("async_reset_done");
        step("after_reset", 16'hF000);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [15:0] p, wa, da;
            logic wr, den;
            r = $urandom_range(0, 59);
            if (r == 0)      set_cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h0220);
            else if (r == 1) set_cfg(16'hE000, 16'hE0FE, 16'hA100, 16'hA1FF);
            else if (r == 2) set_cfg(16'hE000, 16'hE000, 16'h0200, 16'h021F);
            else if (r < 12) set_cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h021F);
            r = $urandom_range(0, 9);
            if (r < 2)      p = 16'hE000;
            else if (r < 5) p = 16'hE000 + 16'($urandom_range(1, 127) * 2);
            else if (r < 7) p = 16'hE0FE;
            else if (r < 9) p = 16'hF000;
            else            p = 16'($urandom);
            wr = ($urandom_range(0, 5) == 0);
            r  = $urandom_range(0, 2);
            wa = (r == 0) ? 16'h0200 + 16'($urandom_range(0, 32)) :
                 (r == 1) ? 16'hE000 + 16'($urandom_range(0, 255)) : 16'h3000;
            den = ($urandom_range(0, 11) == 0);
            da  = $urandom_range(0, 1) ? 16'h021F : 16'hE080;
            drive(p, wr, wa, den, da);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
